// File: rtl/reg_decoder_seq_if.sv
// Control/status bundle for reg_decoder_seq.
//   master: drives en, clr, load, sel, step, dir; observes out, idx, valid, wrap, at_end
//   slave : the decoder side
interface reg_decoder_seq_if #(
  parameter int unsigned SEL_W = 2
) ();
  localparam int unsigned N = 1 << SEL_W;

  logic             en;
  logic             clr;
  logic             load;
  logic [SEL_W-1:0] sel;
  logic             step;
  logic             dir;
  logic [N-1:0]     out;
  logic [SEL_W-1:0] idx;
  logic             valid;
  logic             wrap;
  logic             at_end;

  modport master (
    output en, clr, load, sel, step, dir,
    input  out, idx, valid, wrap, at_end
  );

  modport slave (
    input  en, clr, load, sel, step, dir,
    output out, idx, valid, wrap, at_end
  );
endinterface

// File: rtl/reg_decoder_seq.sv
// Registered one-hot decoder with load, clear and up/down stepping.
//   clk   : rising-edge clock
//   rst   : synchronous active-high reset
//   bus   : reg_decoder_seq_if slave
//           in : en, clr, load, sel, step, dir
//           out: out (one-hot, registered), idx, valid, wrap (registered),
//                at_end (combinational from idx, dir, valid)
// The interface instance must use the same SEL_W as this module.
module reg_decoder_seq #(
  parameter int unsigned SEL_W   = 2,
  parameter bit          WRAP_EN = 1'b1
) (
  input  logic               clk,
  input  logic               rst,
  reg_decoder_seq_if.slave   bus
);
  localparam int unsigned    N       = 1 << SEL_W;
  localparam logic [SEL_W-1:0] IDX_MAX = SEL_W'(N - 1);

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [SEL_W-1:0] idx_q, idx_d;
  logic             wrap_q, wrap_d;
  logic [N-1:0]     out_q, out_d;
  logic             at_top, at_bot;

  assign at_top = (idx_q == IDX_MAX);
  assign at_bot = (idx_q == '0);

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      wrap_q  <= 1'b0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      wrap_q  <= wrap_d;
      out_q   <= out_d;
    end
  end

  // Next state: en gates everything, then clr > load > step
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    wrap_d  = 1'b0;
    out_d   = '0;

    if (bus.en) begin
      if (bus.clr) begin
        state_d = IDLE;
        idx_d   = '0;
      end else if (bus.load) begin
        state_d = ACTIVE;
        idx_d   = bus.sel;
      end else if (bus.step && (state_q == ACTIVE)) begin
        if (bus.dir) begin
          if (!at_top) begin
            idx_d = idx_q + SEL_W'(1);
          end else if (WRAP_EN) begin
            idx_d  = '0;
            wrap_d = 1'b1;
          end
        end else begin
          if (!at_bot) begin
            idx_d = idx_q - SEL_W'(1);
          end else if (WRAP_EN) begin
            idx_d  = IDX_MAX;
            wrap_d = 1'b1;
          end
        end
      end
    end

    // Output register is loaded with the decode of the next index
    if (state_d == ACTIVE) begin
      out_d[idx_d] = 1'b1;
    end
  end

  assign bus.out    = out_q;
  assign bus.idx    = idx_q;
  assign bus.valid  = (state_q == ACTIVE);
  assign bus.wrap   = wrap_q;
  assign bus.at_end = (state_q == ACTIVE) && (bus.dir ? at_top : at_bot);
endmodule

// File: tb/tb_reg_decoder_seq.sv
// Bench for reg_decoder_seq: two instances (SEL_W=2 wrapping, SEL_W=3 saturating),
// a per-cycle reference model plus directed literal expectations.
module tb_reg_decoder_seq;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  reg_decoder_seq_if #(.SEL_W(2)) ifa ();
  reg_decoder_seq_if #(.SEL_W(3)) ifb ();

  reg_decoder_seq #(.SEL_W(2), .WRAP_EN(1'b1)) dut_a (.clk(clk), .rst(rst), .bus(ifa));
  reg_decoder_seq #(.SEL_W(3), .WRAP_EN(1'b0)) dut_b (.clk(clk), .rst(rst), .bus(ifb));

  int n_checks = 0;
  int n_pass   = 0;
  bit chk_on   = 1'b0;

  typedef struct {
    bit active;
    int idx;
    bit wrap;
  } mstate_t;

  mstate_t ma = '{active: 1'b0, idx: 0, wrap: 1'b0};
  mstate_t mb = '{active: 1'b0, idx: 0, wrap: 1'b0};

  function automatic mstate_t model_next(mstate_t s, int n, bit wrap_en, bit r, bit en,
                                         bit clr, bit load, int sel, bit step, bit dir);
    mstate_t t;
    int p;
    t      = s;
    t.wrap = 1'b0;
    if (r) begin
      t.active = 1'b0;
      t.idx    = 0;
    end else if (en) begin
      if (clr) begin
        t.active = 1'b0;
        t.idx    = 0;
      end else if (load) begin
        t.active = 1'b1;
        t.idx    = sel;
      end else if (step && s.active) begin
        p = s.idx + (dir ? 1 : -1);
        if (p < 0 || p >= n) begin
          if (wrap_en) begin
            t.idx  = (p + n) % n;
            t.wrap = 1'b1;
          end
        end else begin
          t.idx = p;
        end
      end
    end
    return t;
  endfunction

  always @(posedge clk) begin
    ma <= model_next(ma, 4, 1'b1, rst, ifa.en, ifa.clr, ifa.load, int'(ifa.sel), ifa.step, ifa.dir);
    mb <= model_next(mb, 8, 1'b0, rst, ifb.en, ifb.clr, ifb.load, int'(ifb.sel), ifb.step, ifb.dir);
  end

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  function automatic logic [31:0] exp_out(mstate_t s);
    return s.active ? (32'd1 << s.idx) : 32'd0;
  endfunction

  function automatic logic [31:0] exp_at_end(mstate_t s, int n, bit dir);
    return {31'd0, s.active && (dir ? (s.idx == n - 1) : (s.idx == 0))};
  endfunction

  // Per-cycle comparison against the model, away from the active edge
  always @(negedge clk) begin
    if (chk_on) begin
      check("a_out",    32'(ifa.out),    exp_out(ma));
      check("a_idx",    32'(ifa.idx),    32'(ma.idx));
      check("a_valid",  32'(ifa.valid),  32'(ma.active));
      check("a_wrap",   32'(ifa.wrap),   32'(ma.wrap));
      check("a_at_end", 32'(ifa.at_end), exp_at_end(ma, 4, ifa.dir));
      check("b_out",    32'(ifb.out),    exp_out(mb));
      check("b_idx",    32'(ifb.idx),    32'(mb.idx));
      check("b_valid",  32'(ifb.valid),  32'(mb.active));
      check("b_wrap",   32'(ifb.wrap),   32'(mb.wrap));
      check("b_at_end", 32'(ifb.at_end), exp_at_end(mb, 8, ifb.dir));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drv_a(bit en, bit clr, bit load, logic [1:0] sel, bit step, bit dir);
    ifa.en = en; ifa.clr = clr; ifa.load = load; ifa.sel = sel; ifa.step = step; ifa.dir = dir;
  endtask

  task automatic drv_b(bit en, bit clr, bit load, logic [2:0] sel, bit step, bit dir);
    ifb.en = en; ifb.clr = clr; ifb.load = load; ifb.sel = sel; ifb.step = step; ifb.dir = dir;
  endtask

  initial begin
    rst = 1'b1;
    drv_a(0, 0, 0, 2'd0, 0, 0);
    drv_b(0, 0, 0, 3'd0, 0, 0);
    tick();
    chk_on = 1'b1;
    tick();

    // Reset / idle
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("idle_out",    32'(ifa.out),    32'd0);
      check("idle_valid",  32'(ifa.valid),  32'd0);
      check("idle_at_end", 32'(ifa.at_end), 32'd0);
    end

    // Exhaustive load
    for (int s = 0; s < 4; s++) begin
      drv_a(1, 0, 1, 2'(s), 0, 0);
      tick();
      check("load_out", 32'(ifa.out), 32'd1 << s);
      check("load_idx", 32'(ifa.idx), 32'(s));
    end
    check("model_pin_load", 32'(ma.idx), 32'd3);

    // Wrap up then down
    drv_a(1, 0, 1, 2'd2, 0, 0);
    tick();
    drv_a(1, 0, 0, 2'd0, 1, 1);
    tick(); check("up_idx3", 32'(ifa.idx), 32'd3); check("up_wrap3", 32'(ifa.wrap), 32'd0);
    tick(); check("up_idx0", 32'(ifa.idx), 32'd0); check("up_wrap0", 32'(ifa.wrap), 32'd1);
    check("model_pin_wrap", 32'(ma.wrap), 32'd1);
    tick(); check("up_idx1", 32'(ifa.idx), 32'd1); check("up_wrap1", 32'(ifa.wrap), 32'd0);
    drv_a(1, 0, 0, 2'd0, 1, 0);
    tick(); check("dn_idx0", 32'(ifa.idx), 32'd0); check("dn_wrap0", 32'(ifa.wrap), 32'd0);
    tick(); check("dn_idx3", 32'(ifa.idx), 32'd3); check("dn_wrap3", 32'(ifa.wrap), 32'd1);
    check("dn_out3", 32'(ifa.out), 32'h8);
    drv_a(0, 0, 0, 2'd0, 1, 0);
    tick(); check("en0_wrap", 32'(ifa.wrap), 32'd0); check("en0_idx", 32'(ifa.idx), 32'd3);

    // Saturate on the non-wrapping instance
    drv_a(0, 0, 0, 2'd0, 0, 0);
    drv_b(1, 0, 1, 3'd6, 0, 1);
    tick();
    check("sat_load_idx", 32'(ifb.idx), 32'd6);
    drv_b(1, 0, 0, 3'd0, 1, 1);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("sat_idx",    32'(ifb.idx),    32'd7);
      check("sat_out",    32'(ifb.out),    32'h80);
      check("sat_wrap",   32'(ifb.wrap),   32'd0);
      check("sat_at_end", 32'(ifb.at_end), 32'd1);
    end
    check("model_pin_sat", 32'(mb.idx), 32'd7);
    drv_b(0, 0, 0, 3'd0, 0, 0);

    // Priority and enable
    drv_a(1, 0, 1, 2'd1, 1, 1);
    tick(); check("ld_over_step", 32'(ifa.idx), 32'd1);
    drv_a(0, 0, 1, 2'd3, 0, 0);
    tick(); check("en0_hold_out", 32'(ifa.out), 32'h2);
    drv_a(1, 1, 1, 2'd2, 0, 0);
    tick(); check("clr_out", 32'(ifa.out), 32'd0); check("clr_valid", 32'(ifa.valid), 32'd0);
    drv_a(1, 0, 0, 2'd0, 1, 1);
    tick(); check("idle_step_valid", 32'(ifa.valid), 32'd0); check("idle_step_idx", 32'(ifa.idx), 32'd0);

    // Reset mid-walk
    drv_a(1, 0, 1, 2'd0, 0, 1);
    tick();
    drv_a(1, 0, 0, 2'd0, 1, 1);
    tick();
    tick(); check("walk_idx2", 32'(ifa.idx), 32'd2);
    rst = 1'b1;
    drv_a(1, 0, 1, 2'd3, 1, 1);
    tick();
    check("rst_out",   32'(ifa.out),   32'd0);
    check("rst_valid", 32'(ifa.valid), 32'd0);
    check("rst_idx",   32'(ifa.idx),   32'd0);
    check("rst_wrap",  32'(ifa.wrap),  32'd0);
    rst = 1'b0;
    drv_a(0, 0, 0, 2'd0, 0, 0);
    tick();
    tick();

    chk_on = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/reg_decoder_seq.md
Name: reg_decoder_seq

Overview:
- Parametrised, registered successor to the team's 2x4 combinational decoder: decodes an SEL_W-bit select into a one-hot output vector of 2^SEL_W lines.
- Adds a clocked output register, enable and clear controls, and a step mode that walks the active line up or down.
- Optional wrap-around at the ends of the range.
- Used as a one-hot channel/row selector and scan sequencer feeding mux and register-file enables.

Parameters:
SEL_W, 2, select width; output count N = 2^SEL_W (legal 1..6)
WRAP_EN, 1, 1 = stepping past an end wraps to the other end; 0 = saturate at the end

Ports:
clk  input  1  system clock, rising-edge
rst  input  1  synchronous reset, active-high
en  input  1  global update enable; when 0, all state holds (rst still acts)
clr  input  1  return to IDLE, outputs all zero
load  input  1  decode sel into out
sel  input  SEL_W  select value sampled on load
step  input  1  move active line by one position
dir  input  1  step direction: 1 = up (index+1), 0 = down (index-1)
out  output  N  registered one-hot decode; all zero when idle
idx  output  SEL_W  binary index of the active line; 0 when idle
valid  output  1  1 when out holds an active line (ACTIVE state)
wrap  output  1  one-cycle pulse on a step that wrapped
at_end  output  1  1 when the active line is at the end in the current dir (idx = N-1 with dir=1, or idx = 0 with dir=0) and valid=1

Behaviour:
- One clock domain; reset is synchronous and active-high. All state changes on the rising edge of clk.
- Reset values: out=0, idx=0, valid=0, wrap=0. at_end=0 follows from valid=0.
- States:
  - IDLE: valid=0, out=0.
  - ACTIVE: valid=1, out = 1<<idx.
- Priority each edge: rst > (!en: hold everything, wrap<=0) > clr > load > step.
- clr: next state IDLE, out=0, idx=0, wrap=0. Legal in either state.
- load (en=1, clr=0):
  - next state ACTIVE, idx<=sel, out<=1<<sel, wrap<=0.
  - Latency 1 cycle from the sampled edge to out.
  - load in ACTIVE overrides any simultaneous step.
- step in ACTIVE (en=1, clr=0, load=0):
  - dir=1: idx<=idx+1. dir=0: idx<=idx-1.
  - At idx=N-1 with dir=1, or idx=0 with dir=0:
    - WRAP_EN=1: idx wraps to 0 or N-1 respectively; wrap<=1 for exactly that cycle.
    - WRAP_EN=0: idx holds, wrap stays 0, at_end stays 1.
  - out always equals 1<<idx in ACTIVE. Never more than one bit set; never zero while valid=1.
- step in IDLE: ignored; state remains IDLE, wrap=0.
- wrap is cleared on every edge that does not produce a wrap, including the !en cycle (wrap<=0).
- at_end is combinational from idx, dir and valid; all other outputs are registered.
- Mid-operation reset: rst during a step sequence returns all outputs to reset values on the next edge, regardless of en, clr or load.
- SEL_W=1: N=2. Steps alternate between lines 0 and 1; the wrap rules above still apply.

Test Plan:
1. Reset/idle: rst=1 for 2 cycles, then rst=0 with all controls 0 -> out=0, idx=0, valid=0, wrap=0, at_end=0 held.
2. Exhaustive load (SEL_W=2): load sel=0,1,2,3 on successive cycles -> next-cycle out=0001,0010,0100,1000; idx matches sel; valid=1.
3. Wrap up/down (WRAP_EN=1, SEL_W=2):
   - load sel=2, then step dir=1 x3 -> idx 3,0,1; wrap=1 only on the 3->0 cycle.
   - Then step dir=0 x2 -> idx 0,3; wrap=1 on the 0->3 cycle.
4. Saturate (WRAP_EN=0, SEL_W=3): load sel=6, step dir=1 x3 -> idx 7,7,7; out=8'h80; wrap never set; at_end=1 from the first 7.
5. Priority and enable:
   - load sel=1 with step=1 same cycle -> idx=1 (load wins).
   - en=0 with load sel=3 -> out unchanged.
   - clr+load together -> IDLE, out=0.
   - step while IDLE -> stays IDLE.
6. Reset mid-walk: walk steps 0->1->2, assert rst with load=1 sel=3 -> next cycle out=0, valid=0, idx=0, wrap=0.
